dense_layer_sequencer: RTL



---
 rtl/dense_layer_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dense_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_sequencer
// Brief    : Runs one fully-connected layer one neuron at a time on a single
//            serial MAC, with bias add, floor shift, saturation and optional ReLU.
// Revision : 1.0
// ============================================================================
module dense_layer_sequencer #(
  parameter int N           = 16,
  parameter int Q           = 8,
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 4,
  parameter int ACT_RELU    = 1,
  localparam int c_iaw = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int c_waw = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
  localparam int c_baw = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [c_iaw-1:0] in_addr,
  input  logic [N-1:0]     in_data,
  output logic [c_waw-1:0] w_addr,
  input  logic [N-1:0]     w_data,
  output logic [c_baw-1:0] b_addr,
  input  logic [N-1:0]     b_data,
  output logic             out_wr_en,
  output logic [c_baw-1:0] out_addr,
  output logic [N-1:0]     out_data
);

  localparam int c_aw = 2 * N + c_iaw + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_MAC   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   r_state;
  logic [c_iaw-1:0]         r_k;
  logic [c_baw-1:0]         r_neuron;
  logic signed [c_aw-1:0]   r_acc;
  logic signed [N-1:0]      r_bias;

  logic signed [2*N-1:0]    w_in_ext;
  logic signed [2*N-1:0]    w_wt_ext;
  logic signed [2*N-1:0]    w_prod;
  logic signed [c_aw-1:0]   w_sum;
  logic signed [c_aw-1:0]   w_shift;
  logic [N-1:0]             w_act;

  // Operands are widened first so the low 2N bits hold the exact signed product.
  assign w_in_ext = {{N{in_data[N-1]}}, in_data};
  assign w_wt_ext = {{N{w_data[N-1]}}, w_data};
  assign w_prod   = w_in_ext * w_wt_ext;
  assign w_sum    = r_acc + (c_aw'(r_bias) <<< Q);
  assign w_shift  = w_sum >>> Q;

  always_comb begin
    w_act = w_shift[N-1:0];
    if (w_shift[c_aw-1:N-1] != {(c_aw-N+1){w_shift[c_aw-1]}}) begin
      w_act = w_shift[c_aw-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
    if ((ACT_RELU != 0) && w_act[N-1]) begin
      w_act = '0;
    end
  end

  // Addresses are registered one cycle ahead so read data lines up with r_k.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_neuron  <= '0;
      r_acc     <= '0;
      r_bias    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_addr   <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      out_wr_en <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_wr_en <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neuron <= '0;
            in_addr  <= '0;
            w_addr   <= '0;
            b_addr   <= '0;
            busy     <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_acc <= '0;
          r_k   <= '0;
          if (NUM_INPUTS > 1) begin
            in_addr <= in_addr + c_iaw'(1);
            w_addr  <= w_addr + c_waw'(1);
          end
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= r_acc + c_aw'(w_prod);
          if (r_k == '0) begin
            r_bias <= b_data;
          end
          if (int'(r_k) + 2 < NUM_INPUTS) begin
            in_addr <= in_addr + c_iaw'(1);
            w_addr  <= w_addr + c_waw'(1);
          end
          if (int'(r_k) == NUM_INPUTS - 1) begin
            r_state <= S_FINAL;
          end else begin
            r_k <= r_k + c_iaw'(1);
          end
        end
        S_FINAL: begin
          out_data  <= w_act;
          out_addr  <= r_neuron;
          out_wr_en <= 1'b1;
          if (int'(r_neuron) + 1 < NUM_NEURONS) begin
            r_neuron <= r_neuron + c_baw'(1);
            b_addr   <= b_addr + c_baw'(1);
            in_addr  <= '0;
            w_addr   <= w_addr + c_waw'(1);
            r_state  <= S_ISSUE;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
